// File: rtl/sprite_addr_pkg.sv
// Shared types and default screen geometry for the sprite address streamer.
// Imported by sprite_base_calc and sprite_addr_streamer.
package sprite_addr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int GRID_DEF     = 10;

endpackage

// File: rtl/sprite_base_calc.sv
// Combinational corner-address and screen-bounds computation from a latched x,y.
// The bounds test exists only when SPRITE_ADDR_BOUNDS_CHECK_EN is defined.
module sprite_base_calc
  import sprite_addr_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int GRID     = GRID_DEF,
  parameter int SPR_W    = 40,
  parameter int SPR_H    = 30,
  parameter int COORD_W  = 6,
  parameter int ADDR_W   = 19
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic [ADDR_W-1:0]  base_o,
  output logic [ADDR_W-1:0]  lower_right_o,
  output logic               oob_o
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(GRID * SCREEN_W);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(GRID);
  localparam logic [ADDR_W-1:0] LR_OFS   =
    ADDR_W'((SPR_H - 1) * SCREEN_W + (SPR_W - 1));

  assign base_o = ADDR_W'(y_i) * ROW_STEP
                + ADDR_W'(x_i) * COL_STEP;

  assign lower_right_o = base_o + LR_OFS;

`ifdef SPRITE_ADDR_BOUNDS_CHECK_EN
  logic [31:0] x_end;
  logic [31:0] y_end;

  // Evaluated at 32 bits so the test never sees a wrapped address.
  assign x_end = 32'(x_i) * 32'(GRID) + 32'(SPR_W);
  assign y_end = 32'(y_i) * 32'(GRID) + 32'(SPR_H);
  assign oob_o = (x_end > 32'(SCREEN_W))
              || (y_end > 32'(SCREEN_H));
`else
  assign oob_o = 1'b0;
`endif

endmodule

// File: rtl/sprite_addr_streamer.sv
// Latches a grid coordinate, registers sprite corners, then streams every
// pixel address over valid/ready. Optional SPRITE_ADDR_BOUNDS_CHECK_EN rejects off-screen sprites.
module sprite_addr_streamer
  import sprite_addr_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int GRID     = GRID_DEF,
  parameter int SPR_W    = 40,
  parameter int SPR_H    = 30,
  parameter int COORD_W  = 6,
  parameter int ADDR_W   = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] input_x,
  input  logic [COORD_W-1:0] input_y,
  output logic               busy,
  output logic [ADDR_W-1:0]  upper_left_address,
  output logic [ADDR_W-1:0]  lower_right_address,
  output logic [ADDR_W-1:0]  addr,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic               addr_last,
  output logic               done,
  output logic               err
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [CW-1:0] COL_END = CW'(SPR_W - 1);
  localparam logic [RW-1:0] ROW_END = RW'(SPR_H - 1);
  localparam logic [ADDR_W-1:0] ROW_JUMP =
    ADDR_W'(SCREEN_W - SPR_W + 1);

  state_e state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ul_q, ul_d, lr_q, lr_d;
  logic err_q, err_d;

  logic [ADDR_W-1:0] base, lr_addr;
  logic oob, at_col_end, at_last;

  sprite_base_calc #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .GRID     (GRID),
    .SPR_W    (SPR_W),
    .SPR_H    (SPR_H),
    .COORD_W  (COORD_W),
    .ADDR_W   (ADDR_W)
  ) u_calc (
    .x_i           (x_q),
    .y_i           (y_q),
    .base_o        (base),
    .lower_right_o (lr_addr),
    .oob_o         (oob)
  );

  assign at_col_end = (col_q == COL_END);
  assign at_last    = at_col_end && (row_q == ROW_END);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    ul_d    = ul_q;
    lr_d    = lr_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = input_x;
          y_d     = input_y;
          state_d = CALC;
        end
      end
      CALC: begin
        if (oob) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          ul_d    = base;
          lr_d    = lr_addr;
          addr_d  = base;
          col_d   = '0;
          row_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (addr_ready) begin
          if (at_last) begin
            state_d = DONE;
          end else if (at_col_end) begin
            addr_d = addr_q + ROW_JUMP;
            col_d  = '0;
            row_d  = row_q + RW'(1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            col_d  = col_q + CW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      ul_q    <= '0;
      lr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      ul_q    <= ul_d;
      lr_q    <= lr_d;
      err_q   <= err_d;
    end
  end

  assign busy                = (state_q != IDLE);
  assign addr_valid          = (state_q == STREAM);
  assign addr_last           = addr_valid && at_last;
  assign done                = (state_q == DONE);
  assign err                 = err_q;
  assign addr                = addr_q;
  assign upper_left_address  = ul_q;
  assign lower_right_address = lr_q;

endmodule
